// File: rtl/huc6270_pkg.sv
// Shared VRAM arbitration types: requester tags and the default CPU starvation limit.
package huc6270_pkg;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_BG   = 2'd1,
    TAG_SPR  = 2'd2,
    TAG_CPU  = 2'd3
  } req_tag_e;

  localparam int unsigned STARVE_LIMIT_DEF = 8;
  localparam int unsigned STARVE_W         = 4;

endpackage

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter for background, sprite and CPU requesters with
// display-dependent priority, CPU starvation override and 1-cycle read return tagging.
module vram_arbiter
  import huc6270_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        display_active,
  input  logic        bg_req,
  input  logic [15:0] bg_addr,
  output logic        bg_gnt,
  output logic        bg_rvalid,
  input  logic        spr_req,
  input  logic [15:0] spr_addr,
  output logic        spr_gnt,
  output logic        spr_rvalid,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [15:0] rdata,
  output logic [15:0] vram_MA,
  output logic        vram_re,
  output logic        vram_we,
  output logic [15:0] vram_MD_in,
  input  logic [15:0] vram_MD_out
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);
  localparam logic [STARVE_W-1:0] SAT   = '1;

  req_tag_e            win;
  req_tag_e            tag_q, tag_d;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  logic                cpu_forced;

  assign cpu_forced = display_active && cpu_req && (starve_cnt_q >= LIMIT);

  // Priority pick; reset suppresses every grant so outputs stay quiet while held.
  always_comb begin
    win = TAG_NONE;
    if (!reset) begin
      if (cpu_forced) begin
        win = TAG_CPU;
      end else if (display_active) begin
        if (bg_req)       win = TAG_BG;
        else if (spr_req) win = TAG_SPR;
        else if (cpu_req) win = TAG_CPU;
      end else begin
        if (cpu_req)      win = TAG_CPU;
        else if (bg_req)  win = TAG_BG;
        else if (spr_req) win = TAG_SPR;
      end
    end
  end

  always_comb begin
    bg_gnt     = (win == TAG_BG);
    spr_gnt    = (win == TAG_SPR);
    cpu_gnt    = (win == TAG_CPU);
    vram_MA    = '0;
    vram_re    = 1'b0;
    vram_we    = 1'b0;
    vram_MD_in = '0;
    tag_d      = TAG_NONE;
    case (win)
      TAG_BG: begin
        vram_MA = bg_addr;
        vram_re = 1'b1;
        tag_d   = TAG_BG;
      end
      TAG_SPR: begin
        vram_MA = spr_addr;
        vram_re = 1'b1;
        tag_d   = TAG_SPR;
      end
      TAG_CPU: begin
        vram_MA = cpu_addr;
        if (cpu_we) begin
          vram_we    = 1'b1;
          vram_MD_in = cpu_wdata;
        end else begin
          vram_re = 1'b1;
          tag_d   = TAG_CPU;
        end
      end
      default: ;
    endcase
  end

  // Starvation only accumulates while the display is stealing the bus.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!cpu_req || cpu_gnt) begin
      starve_cnt_d = '0;
    end else if (display_active && (starve_cnt_q != SAT)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tag_q        <= TAG_NONE;
      starve_cnt_q <= '0;
    end else begin
      tag_q        <= tag_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign bg_rvalid  = (tag_q == TAG_BG);
  assign spr_rvalid = (tag_q == TAG_SPR);
  assign cpu_rvalid = (tag_q == TAG_CPU);
  assign rdata      = vram_MD_out;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: VRAM memory model, cycle-level behavioural reference and directed vectors.
module tb_vram_arbiter;

  localparam int LIMIT = 8;

  logic        clk;
  logic        reset;
  logic        display_active;
  logic        bg_req, spr_req, cpu_req, cpu_we;
  logic [15:0] bg_addr, spr_addr, cpu_addr, cpu_wdata;
  logic        bg_gnt, spr_gnt, cpu_gnt;
  logic        bg_rvalid, spr_rvalid, cpu_rvalid;
  logic [15:0] rdata, vram_MA, vram_MD_in, vram_MD_out;
  logic        vram_re, vram_we;

  int n_chk  = 0;
  int n_fail = 0;

  vram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clock(clk), .reset(reset), .display_active(display_active),
    .bg_req(bg_req), .bg_addr(bg_addr), .bg_gnt(bg_gnt), .bg_rvalid(bg_rvalid),
    .spr_req(spr_req), .spr_addr(spr_addr), .spr_gnt(spr_gnt), .spr_rvalid(spr_rvalid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .rdata(rdata),
    .vram_MA(vram_MA), .vram_re(vram_re), .vram_we(vram_we),
    .vram_MD_in(vram_MD_in), .vram_MD_out(vram_MD_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // VRAM device: registered read, write on the enable edge
  logic [15:0] vram [0:65535];
  logic [15:0] mmem [0:65535];
  initial begin
    for (int i = 0; i < 65536; i++) begin
      vram[i] = 16'(i) ^ 16'hA5A5;
      mmem[i] = 16'(i) ^ 16'hA5A5;
    end
  end
  always @(posedge clk) begin
    if (vram_re) vram_MD_out <= vram[vram_MA];
    if (vram_we) vram[vram_MA] <= vram_MD_in;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Reference: owner 0=none 1=bg 2=spr 3=cpu; m_wait counts display cycles the CPU has waited
  int          m_owner = 0;
  int          m_wait  = 0;
  logic [15:0] m_data  = '0;

  always @(negedge clk) begin
    int          win;
    logic [15:0] e_ma, e_md;
    logic        e_re, e_we;
    if (reset) begin
      chk("m_rst_bg_gnt", bg_gnt, 0);
      chk("m_rst_spr_gnt", spr_gnt, 0);
      chk("m_rst_cpu_gnt", cpu_gnt, 0);
      chk("m_rst_rvalid", {bg_rvalid, spr_rvalid, cpu_rvalid}, 0);
      chk("m_rst_vram", {vram_re, vram_we, vram_MA, vram_MD_in}, 0);
      m_owner = 0;
      m_wait  = 0;
    end else begin
      win = 0;
      if (display_active) begin
        if (cpu_req && m_wait >= LIMIT) win = 3;
        else if (bg_req)  win = 1;
        else if (spr_req) win = 2;
        else if (cpu_req) win = 3;
      end else begin
        if (cpu_req)      win = 3;
        else if (bg_req)  win = 1;
        else if (spr_req) win = 2;
      end
      e_ma = 16'h0; e_md = 16'h0; e_re = 1'b0; e_we = 1'b0;
      if (win == 1) begin e_ma = bg_addr;  e_re = 1'b1; end
      if (win == 2) begin e_ma = spr_addr; e_re = 1'b1; end
      if (win == 3) begin
        e_ma = cpu_addr;
        if (cpu_we) begin e_we = 1'b1; e_md = cpu_wdata; end
        else e_re = 1'b1;
      end
      chk("m_bg_gnt", bg_gnt, win == 1);
      chk("m_spr_gnt", spr_gnt, win == 2);
      chk("m_cpu_gnt", cpu_gnt, win == 3);
      chk("m_vram_re", vram_re, e_re);
      chk("m_vram_we", vram_we, e_we);
      chk("m_vram_MA", vram_MA, e_ma);
      chk("m_vram_MD_in", vram_MD_in, e_md);
      chk("m_bg_rvalid", bg_rvalid, m_owner == 1);
      chk("m_spr_rvalid", spr_rvalid, m_owner == 2);
      chk("m_cpu_rvalid", cpu_rvalid, m_owner == 3);
      if (m_owner != 0) chk("m_rdata", rdata, m_data);
      // state after the coming edge
      if (win == 3 && cpu_we) begin
        mmem[cpu_addr] = cpu_wdata;
        m_owner = 0;
      end else if (win != 0) begin
        m_owner = win;
        m_data  = mmem[e_ma];
      end else begin
        m_owner = 0;
      end
      if (!cpu_req || win == 3) m_wait = 0;
      else if (display_active)  m_wait = m_wait + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bg_req = 0; spr_req = 0; cpu_req = 0; cpu_we = 0;
  endtask

  initial begin
    int n;
    reset = 1; display_active = 1; idle();
    bg_addr = 16'h1234; spr_addr = 0; cpu_addr = 0; cpu_wdata = 0;
    bg_req = 1;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_bg_gnt", bg_gnt, 0);
    chk("rst_vram_MA", vram_MA, 16'h0000);
    tick();
    reset = 0; idle();

    // all three request during display, counter at zero -> bg wins
    tick();
    bg_req = 1; spr_req = 1; cpu_req = 1; cpu_we = 0;
    bg_addr = 16'h0100; spr_addr = 16'h0200; cpu_addr = 16'h0300;
    #2;
    chk("all_req_bg_gnt", bg_gnt, 1);
    chk("all_req_vram_re", vram_re, 1);
    chk("all_req_vram_MA", vram_MA, 16'h0100);
    tick();
    idle();
    #2;
    chk("all_req_bg_rvalid", bg_rvalid, 1);
    chk("all_req_rdata", rdata, 16'hA4A5);

    // starvation: cpu read waits behind a continuous bg stream
    tick();
    bg_req = 1; bg_addr = 16'h0010; cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0020;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      #2;
      if (cpu_gnt) begin n = i; break; end
      tick();
    end
    chk("starve_grant_cycle", n, 9);
    chk("starve_bg_preempted", bg_gnt, 0);
    tick();
    cpu_req = 0;
    #2;
    chk("starve_cpu_rvalid", cpu_rvalid, 1);
    chk("starve_rdata", rdata, 16'hA585);
    chk("starve_bg_resumes", bg_gnt, 1);
    tick();
    idle();

    // blanking: cpu write beats bg, then bg reads the written word back
    tick();
    display_active = 0;
    bg_req = 1; bg_addr = 16'h7FFF;
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h7FFF; cpu_wdata = 16'hBEEF;
    #2;
    chk("blank_cpu_gnt", cpu_gnt, 1);
    chk("blank_vram_we", vram_we, 1);
    chk("blank_vram_re", vram_re, 0);
    chk("blank_MD_in", vram_MD_in, 16'hBEEF);
    tick();
    cpu_req = 0; cpu_we = 0;
    #2;
    chk("write_no_rvalid", {bg_rvalid, spr_rvalid, cpu_rvalid}, 0);
    chk("blank_bg_gnt", bg_gnt, 1);
    tick();
    bg_req = 0;
    #2;
    chk("readback_rvalid", bg_rvalid, 1);
    chk("readback_rdata", rdata, 16'hBEEF);

    // blanking order bg > spr, then a same-cycle display switch
    tick();
    bg_req = 1; spr_req = 1; bg_addr = 16'h0011; spr_addr = 16'h0022;
    #2;
    chk("blank_bg_over_spr", bg_gnt, 1);
    tick();
    cpu_req = 1; cpu_addr = 16'h0033;
    #2;
    chk("blank_cpu_first", cpu_gnt, 1);
    display_active = 1;
    #1;
    chk("switch_bg_first", bg_gnt, 1);
    tick();
    idle();

    // alternating sprite / cpu reads
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k % 2 == 0) begin spr_req = 1; spr_addr = 16'h0400 + 16'(k); cpu_req = 0; end
      else begin cpu_req = 1; cpu_addr = 16'h0500 + 16'(k); spr_req = 0; end
      #2;
      chk("alt_gnt", {bg_gnt, spr_gnt, cpu_gnt}, (k % 2 == 0) ? 3'b010 : 3'b001);
      if (k > 0) chk("alt_rvalid", {spr_rvalid, cpu_rvalid}, (k % 2 == 0) ? 2'b01 : 2'b10);
    end
    tick();
    idle();
    #2;
    chk("alt_last_rvalid", cpu_rvalid, 1);
    chk("alt_last_rdata", rdata, 16'h0507 ^ 16'hA5A5);

    // reset lands one cycle after a bg read grant
    tick();
    bg_req = 1; bg_addr = 16'h0600;
    #2;
    chk("rr_bg_gnt", bg_gnt, 1);
    tick();
    reset = 1; bg_req = 0;
    #2;
    chk("rr_bg_rvalid", bg_rvalid, 0);
    tick();
    reset = 0;
    #2;
    chk("rr_after_outputs", {bg_rvalid, spr_rvalid, cpu_rvalid, vram_re, vram_we, vram_MA}, 0);
    tick();
    #2;
    chk("rr_still_quiet", bg_rvalid, 0);
    tick();
    spr_req = 1; spr_addr = 16'h0700;
    #2;
    chk("rr_first_gnt", spr_gnt, 1);
    tick();
    spr_req = 0;
    #2;
    chk("rr_spr_rvalid", spr_rvalid, 1);

    // cpu drops its request mid-wait: the wait restarts from zero
    tick();
    bg_req = 1; bg_addr = 16'h0800; cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0900;
    for (int i = 0; i < 5; i++) begin
      #2;
      chk("drop_wait_no_gnt", cpu_gnt, 0);
      tick();
    end
    cpu_req = 0;
    #2;
    chk("drop_no_gnt", cpu_gnt, 0);
    tick();
    cpu_req = 1;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      #2;
      if (cpu_gnt) begin n = i; break; end
      tick();
    end
    chk("drop_restart_cycle", n, 9);
    tick();
    idle();
    #2;
    chk("drop_cpu_rvalid", cpu_rvalid, 1);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
